// File: rtl/pipe_ex_mem_hs_if.sv
// EX -> MEM handshake bundle: valid/ready, flush, instruction payload and stall count.
// The slave modport is the pipeline stage's view; master is the driver/observer side.
interface pipe_ex_mem_hs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TYPE_W = 2,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              out_ex_ready;
    logic              in_mem_ready;
    logic              in_flush;
    logic              in_dmem_ena;
    logic              in_dmem_wena;
    logic              in_rd_sel;
    logic              in_rd_wena;
    logic [TYPE_W-1:0] in_dmem_type;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [DATA_W-1:0] in_alu_result;
    logic [ADDR_W-1:0] in_rd_waddr;
    logic              out_valid;
    logic              out_dmem_ena;
    logic              out_dmem_wena;
    logic              out_rd_sel;
    logic              out_rd_wena;
    logic [TYPE_W-1:0] out_dmem_type;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [ADDR_W-1:0] out_rd_waddr;
    logic [DATA_W-1:0] out_alu_result;
    logic [CNT_W-1:0]  out_stall_cnt;

    modport slave (
        input  in_valid, in_mem_ready, in_flush,
        input  in_dmem_ena, in_dmem_wena, in_rd_sel, in_rd_wena, in_dmem_type,
        input  in_rs_data, in_rt_data, in_alu_result, in_rd_waddr,
        output out_ex_ready, out_valid,
        output out_dmem_ena, out_dmem_wena, out_rd_sel, out_rd_wena, out_dmem_type,
        output out_rs_data, out_rt_data, out_rd_waddr, out_alu_result,
        output out_stall_cnt
    );

    modport master (
        output in_valid, in_mem_ready, in_flush,
        output in_dmem_ena, in_dmem_wena, in_rd_sel, in_rd_wena, in_dmem_type,
        output in_rs_data, in_rt_data, in_alu_result, in_rd_waddr,
        input  out_ex_ready, out_valid,
        input  out_dmem_ena, out_dmem_wena, out_rd_sel, out_rd_wena, out_dmem_type,
        input  out_rs_data, out_rt_data, out_rd_waddr, out_alu_result,
        input  out_stall_cnt
    );
endinterface

// File: rtl/pipe_ex_mem_hs.sv
// EX/MEM pipeline register with valid/ready handshake, optional one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
// state    | meaning
// ST_EMPTY | no entry held, outputs invalid
// ST_FULL  | main entry valid and presented to MEM
// ST_SKID  | main and skid both valid, EX back-pressured (SKID=1 only)
module pipe_ex_mem_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TYPE_W = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input logic               in_clk,
    input logic               in_rst,
    pipe_ex_mem_hs_if.slave   bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    typedef struct packed {
        logic              dmem_ena;
        logic              dmem_wena;
        logic              rd_sel;
        logic              rd_wena;
        logic [TYPE_W-1:0] dmem_type;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] rd_waddr;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    payload_t         in_pl;
    payload_t         main_q;
    payload_t         skid_q;
    logic             main_valid;
    logic             skid_valid;
    logic             ex_ready_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             ex_ready;
    logic             accept;
    logic             drain;

    // Side-effect controls are stored cleared whenever main goes invalid, so the
    // outputs come straight from flops and never show a stale enable.
    function automatic payload_t kill_side(input payload_t p);
        payload_t r;
        r           = p;
        r.dmem_ena  = 1'b0;
        r.dmem_wena = 1'b0;
        r.rd_wena   = 1'b0;
        return r;
    endfunction

    always_comb begin
        in_pl            = '0;
        in_pl.dmem_ena   = bus.in_dmem_ena;
        in_pl.dmem_wena  = bus.in_dmem_wena;
        in_pl.rd_sel     = bus.in_rd_sel;
        in_pl.rd_wena    = bus.in_rd_wena;
        in_pl.dmem_type  = bus.in_dmem_type;
        in_pl.rs_data    = bus.in_rs_data;
        in_pl.rt_data    = bus.in_rt_data;
        in_pl.alu_result = bus.in_alu_result;
        in_pl.rd_waddr   = bus.in_rd_waddr;
    end

    // Without the skid entry, ready must see MEM's ready in the same cycle.
    assign ex_ready = (SKID != 0) ? ex_ready_q : (!main_valid || bus.in_mem_ready);
    assign accept   = bus.in_valid && ex_ready;
    assign drain    = main_valid && bus.in_mem_ready;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state      <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ex_ready_q <= 1'b1;
            stall_cnt  <= '0;
        end else begin
            if (main_valid && !bus.in_mem_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;

            if (bus.in_flush) begin
                state      <= ST_EMPTY;
                main_q     <= kill_side(main_q);
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                ex_ready_q <= 1'b1;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_q     <= in_pl;
                            main_valid <= 1'b1;
                            state      <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (accept && drain) begin
                            main_q <= in_pl;
                        end else if (accept && SKID != 0) begin
                            skid_q     <= in_pl;
                            skid_valid <= 1'b1;
                            ex_ready_q <= 1'b0;
                            state      <= ST_SKID;
                        end else if (drain) begin
                            main_q     <= kill_side(main_q);
                            main_valid <= 1'b0;
                            state      <= ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (drain) begin
                            main_q     <= skid_q;
                            skid_valid <= 1'b0;
                            ex_ready_q <= 1'b1;
                            state      <= ST_FULL;
                        end
                    end
                    default: begin
                        state      <= ST_EMPTY;
                        main_q     <= kill_side(main_q);
                        main_valid <= 1'b0;
                        skid_valid <= 1'b0;
                        ex_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.out_ex_ready   = ex_ready;
    assign bus.out_valid      = main_valid;
    assign bus.out_dmem_ena   = main_q.dmem_ena;
    assign bus.out_dmem_wena  = main_q.dmem_wena;
    assign bus.out_rd_sel     = main_q.rd_sel;
    assign bus.out_rd_wena    = main_q.rd_wena;
    assign bus.out_dmem_type  = main_q.dmem_type;
    assign bus.out_rs_data    = main_q.rs_data;
    assign bus.out_rt_data    = main_q.rt_data;
    assign bus.out_rd_waddr   = main_q.rd_waddr;
    assign bus.out_alu_result = main_q.alu_result;
    assign bus.out_stall_cnt  = stall_cnt;
endmodule

// File: tb/tb_pipe_ex_mem_hs.sv
// Directed bench for pipe_ex_mem_hs: a SKID=1 instance, a SKID=1 CNT_W=4 instance for
// counter saturation, and a SKID=0 instance for the combinational-ready build.
module tb_pipe_ex_mem_hs;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_ex_mem_hs_if #(.CNT_W(16)) if_a ();
    pipe_ex_mem_hs_if #(.CNT_W(4))  if_b ();
    pipe_ex_mem_hs_if #(.CNT_W(16)) if_z ();

    pipe_ex_mem_hs #(.SKID(1), .CNT_W(16)) u_a (.in_clk(clk), .in_rst(rst), .bus(if_a));
    pipe_ex_mem_hs #(.SKID(1), .CNT_W(4))  u_b (.in_clk(clk), .in_rst(rst), .bus(if_b));
    pipe_ex_mem_hs #(.SKID(0), .CNT_W(16)) u_z (.in_clk(clk), .in_rst(rst), .bus(if_z));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        if_a.in_valid = 0; if_a.in_mem_ready = 0; if_a.in_flush = 0;
        if_a.in_dmem_ena = 1; if_a.in_dmem_wena = 1; if_a.in_rd_sel = 1; if_a.in_rd_wena = 1;
        if_a.in_dmem_type = 2'b10; if_a.in_rs_data = 32'hAAAA0001; if_a.in_rt_data = 32'hBBBB0002;
        if_a.in_alu_result = 0; if_a.in_rd_waddr = 5'd7;
        if_b.in_valid = 0; if_b.in_mem_ready = 0; if_b.in_flush = 0;
        if_b.in_dmem_ena = 1; if_b.in_dmem_wena = 1; if_b.in_rd_sel = 1; if_b.in_rd_wena = 1;
        if_b.in_dmem_type = 2'b01; if_b.in_rs_data = 0; if_b.in_rt_data = 0;
        if_b.in_alu_result = 0; if_b.in_rd_waddr = 5'd3;
        if_z.in_valid = 0; if_z.in_mem_ready = 0; if_z.in_flush = 0;
        if_z.in_dmem_ena = 1; if_z.in_dmem_wena = 0; if_z.in_rd_sel = 0; if_z.in_rd_wena = 1;
        if_z.in_dmem_type = 2'b11; if_z.in_rs_data = 0; if_z.in_rt_data = 0;
        if_z.in_alu_result = 0; if_z.in_rd_waddr = 5'd9;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        total++; if (if_a.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_a.out_valid); end
        total++; if (if_a.out_ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", if_a.out_ex_ready); end
        total++; if (if_a.out_alu_result !== 32'h0) begin bad++; $display("FAIL reset_alu: got %h want 0", if_a.out_alu_result); end
        total++; if (if_a.out_dmem_ena !== 1'b0 || if_a.out_rd_wena !== 1'b0) begin bad++; $display("FAIL reset_ena: got %b%b want 00", if_a.out_dmem_ena, if_a.out_rd_wena); end
        total++; if (if_a.out_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", if_a.out_stall_cnt); end
        tick();
        tick();
        rst = 0;
        #1;
        total++; if (if_a.out_valid !== 1'b0 || if_a.out_ex_ready !== 1'b1) begin bad++; $display("FAIL reset_release: got valid=%b ready=%b want 0/1", if_a.out_valid, if_a.out_ex_ready); end
        total++; if (if_z.out_ex_ready !== 1'b1) begin bad++; $display("FAIL reset_noskid_ready: got %b want 1", if_z.out_ex_ready); end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [4];
        vals = '{32'h10, 32'h20, 32'h30, 32'h40};
        if_a.in_valid = 1; if_a.in_mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if_a.in_alu_result = vals[i];
            tick();
            total++; if (if_a.out_valid !== 1'b1 || if_a.out_alu_result !== vals[i]) begin bad++; $display("FAIL stream_data%0d: got v=%b %h want 1 %h", i, if_a.out_valid, if_a.out_alu_result, vals[i]); end
            total++; if (if_a.out_ex_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got %b want 1", i, if_a.out_ex_ready); end
        end
        total++; if (if_a.out_dmem_wena !== 1'b1 || if_a.out_rs_data !== 32'hAAAA0001 || if_a.out_rd_waddr !== 5'd7) begin bad++; $display("FAIL stream_payload: got wena=%b rs=%h wa=%0d want 1 aaaa0001 7", if_a.out_dmem_wena, if_a.out_rs_data, if_a.out_rd_waddr); end
        if_a.in_valid = 0;
        tick();
        total++; if (if_a.out_valid !== 1'b0 || if_a.out_dmem_ena !== 1'b0 || if_a.out_stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_drain: got v=%b ena=%b cnt=%0d want 0 0 0", if_a.out_valid, if_a.out_dmem_ena, if_a.out_stall_cnt); end
    endtask

    task automatic test_skid_fill();
        if_a.in_valid = 1; if_a.in_mem_ready = 0; if_a.in_alu_result = 32'h11;
        tick();
        total++; if (if_a.out_alu_result !== 32'h11 || if_a.out_ex_ready !== 1'b1) begin bad++; $display("FAIL skid_a: got %h ready=%b want 11 1", if_a.out_alu_result, if_a.out_ex_ready); end
        if_a.in_alu_result = 32'h22;
        tick();
        total++; if (if_a.out_alu_result !== 32'h11 || if_a.out_ex_ready !== 1'b0 || if_a.out_stall_cnt !== 16'd1) begin bad++; $display("FAIL skid_b: got %h ready=%b cnt=%0d want 11 0 1", if_a.out_alu_result, if_a.out_ex_ready, if_a.out_stall_cnt); end
        if_a.in_alu_result = 32'h99;
        tick();
        total++; if (if_a.out_alu_result !== 32'h11 || if_a.out_ex_ready !== 1'b0 || if_a.out_stall_cnt !== 16'd2) begin bad++; $display("FAIL skid_hold: got %h ready=%b cnt=%0d want 11 0 2", if_a.out_alu_result, if_a.out_ex_ready, if_a.out_stall_cnt); end
        if_a.in_valid = 0; if_a.in_mem_ready = 1;
        tick();
        total++; if (if_a.out_valid !== 1'b1 || if_a.out_alu_result !== 32'h22 || if_a.out_ex_ready !== 1'b1 || if_a.out_stall_cnt !== 16'd2) begin bad++; $display("FAIL skid_release: got v=%b %h ready=%b cnt=%0d want 1 22 1 2", if_a.out_valid, if_a.out_alu_result, if_a.out_ex_ready, if_a.out_stall_cnt); end
        tick();
        total++; if (if_a.out_valid !== 1'b0 || if_a.out_dmem_ena !== 1'b0) begin bad++; $display("FAIL skid_empty: got v=%b ena=%b want 0 0", if_a.out_valid, if_a.out_dmem_ena); end
    endtask

    task automatic test_flush();
        if_a.in_valid = 1; if_a.in_mem_ready = 0; if_a.in_alu_result = 32'h44;
        tick();
        if_a.in_alu_result = 32'h55;
        tick();
        if_a.in_alu_result = 32'h33; if_a.in_flush = 1;
        tick();
        total++; if (if_a.out_valid !== 1'b0 || if_a.out_dmem_wena !== 1'b0 || if_a.out_rd_wena !== 1'b0 || if_a.out_dmem_ena !== 1'b0) begin bad++; $display("FAIL flush_kill: got v=%b wena=%b rdw=%b ena=%b want 0 0 0 0", if_a.out_valid, if_a.out_dmem_wena, if_a.out_rd_wena, if_a.out_dmem_ena); end
        total++; if (if_a.out_ex_ready !== 1'b1 || if_a.out_stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_ready_cnt: got ready=%b cnt=%0d want 1 4", if_a.out_ex_ready, if_a.out_stall_cnt); end
        if_a.in_flush = 0; if_a.in_valid = 0;
        tick();
        total++; if (if_a.out_valid !== 1'b0 || if_a.out_stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_discard: got v=%b cnt=%0d want 0 4", if_a.out_valid, if_a.out_stall_cnt); end
        if_a.in_valid = 1; if_a.in_mem_ready = 1; if_a.in_alu_result = 32'h66;
        tick();
        total++; if (if_a.out_valid !== 1'b1 || if_a.out_alu_result !== 32'h66) begin bad++; $display("FAIL flush_next: got v=%b %h want 1 66", if_a.out_valid, if_a.out_alu_result); end
        if_a.in_valid = 0;
        tick();
    endtask

    task automatic test_saturation();
        int exp;
        if_b.in_valid = 1; if_b.in_mem_ready = 0; if_b.in_alu_result = 32'h77;
        tick();
        if_b.in_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k < 15) ? k : 15;
            total++; if (if_b.out_stall_cnt !== exp[3:0] || if_b.out_valid !== 1'b1) begin bad++; $display("FAIL sat_cnt%0d: got cnt=%0d v=%b want %0d 1", k, if_b.out_stall_cnt, if_b.out_valid, exp); end
        end
    endtask

    task automatic test_no_skid();
        if_z.in_valid = 0; if_z.in_mem_ready = 0;
        #1;
        total++; if (if_z.out_ex_ready !== 1'b1) begin bad++; $display("FAIL noskid_empty_ready: got %b want 1", if_z.out_ex_ready); end
        if_z.in_valid = 1; if_z.in_mem_ready = 1; if_z.in_alu_result = 32'h01;
        tick();
        total++; if (if_z.out_valid !== 1'b1 || if_z.out_alu_result !== 32'h01) begin bad++; $display("FAIL noskid_first: got v=%b %h want 1 01", if_z.out_valid, if_z.out_alu_result); end
        if_z.in_mem_ready = 0; if_z.in_alu_result = 32'h02;
        #1;
        total++; if (if_z.out_ex_ready !== 1'b0) begin bad++; $display("FAIL noskid_ready_low: got %b want 0", if_z.out_ex_ready); end
        tick();
        total++; if (if_z.out_alu_result !== 32'h01 || if_z.out_stall_cnt !== 16'd1) begin bad++; $display("FAIL noskid_hold: got %h cnt=%0d want 01 1", if_z.out_alu_result, if_z.out_stall_cnt); end
        if_z.in_mem_ready = 1;
        #1;
        total++; if (if_z.out_ex_ready !== 1'b1) begin bad++; $display("FAIL noskid_ready_high: got %b want 1", if_z.out_ex_ready); end
        tick();
        total++; if (if_z.out_alu_result !== 32'h02) begin bad++; $display("FAIL noskid_second: got %h want 02", if_z.out_alu_result); end
        if_z.in_alu_result = 32'h03;
        tick();
        total++; if (if_z.out_alu_result !== 32'h03 || if_z.out_valid !== 1'b1) begin bad++; $display("FAIL noskid_third: got v=%b %h want 1 03", if_z.out_valid, if_z.out_alu_result); end
        if_z.in_valid = 0;
        tick();
        total++; if (if_z.out_valid !== 1'b0 || if_z.out_rd_wena !== 1'b0) begin bad++; $display("FAIL noskid_empty: got v=%b rdw=%b want 0 0", if_z.out_valid, if_z.out_rd_wena); end
    endtask

    task automatic test_async_reset();
        if_a.in_valid = 1; if_a.in_mem_ready = 0; if_a.in_alu_result = 32'hA1;
        tick();
        if_a.in_alu_result = 32'hA2;
        tick();
        total++; if (if_a.out_ex_ready !== 1'b0 || if_a.out_alu_result !== 32'hA1) begin bad++; $display("FAIL arst_pre: got ready=%b %h want 0 a1", if_a.out_ex_ready, if_a.out_alu_result); end
        if_a.in_valid = 0;
        #3;
        rst = 1;
        #1;
        total++; if (if_a.out_valid !== 1'b0 || if_a.out_ex_ready !== 1'b1 || if_a.out_stall_cnt !== 16'd0) begin bad++; $display("FAIL arst_clear: got v=%b ready=%b cnt=%0d want 0 1 0", if_a.out_valid, if_a.out_ex_ready, if_a.out_stall_cnt); end
        total++; if (if_a.out_alu_result !== 32'h0 || if_a.out_dmem_ena !== 1'b0 || if_a.out_rs_data !== 32'h0) begin bad++; $display("FAIL arst_payload: got %h ena=%b rs=%h want 0 0 0", if_a.out_alu_result, if_a.out_dmem_ena, if_a.out_rs_data); end
        tick();
        rst = 0;
        if_a.in_valid = 1; if_a.in_mem_ready = 1; if_a.in_alu_result = 32'hB1;
        tick();
        total++; if (if_a.out_valid !== 1'b1 || if_a.out_alu_result !== 32'hB1) begin bad++; $display("FAIL arst_after: got v=%b %h want 1 b1", if_a.out_valid, if_a.out_alu_result); end
        if_a.in_valid = 0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        init_inputs();
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush();
        test_saturation();
        test_no_skid();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
